// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, default constants and Galois step for the BIST engine
package bist_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COMPARE = 2'd2, DONE = 2'd3} state_t;
    localparam logic [7:0] DEF_POLY_TAPS = 8'hB8;
    localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
    // Operands are zero-extended to 64 bits so one function serves any WIDTH up to 64
    function automatic logic [63:0] galois_step(input logic [63:0] v, input logic [63:0] taps);
        return (v >> 1) ^ (v[0] ? taps : 64'd0);
    endfunction
endpackage

// File: rtl/lfsr_misr.sv
// lfsr_misr: Galois shift register, used as pattern LFSR (din=0) or as response MISR
module lfsr_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY_TAPS = WIDTH'(DEF_POLY_TAPS),
    parameter logic [WIDTH-1:0] SEED      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || load) q <= SEED;
        else if (en) q <= WIDTH'(galois_step(64'(q), 64'(POLY_TAPS))) ^ din;
    end
endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR pattern generator + MISR compactor answering the controller's BIST handshake
// Optional macro BIST_FAULT_INJECT_EN adds fault_inject, flipping cut_resp[0] into the MISR during RUN.
module bist_engine
    import bist_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               NUM_PATTERNS = 16,
    parameter logic [WIDTH-1:0] LFSR_SEED    = WIDTH'(DEF_LFSR_SEED),
    parameter logic [WIDTH-1:0] POLY_TAPS    = WIDTH'(DEF_POLY_TAPS),
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_bist,
    output logic             bist_active,
    output logic             bist_pass,
    output logic             bist_done,
    output logic [WIDTH-1:0] tpg_a,
    output logic [WIDTH-1:0] tpg_b,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] signature
`ifdef BIST_FAULT_INJECT_EN
    ,
    input  logic             fault_inject
`endif
);
    localparam int CW = $clog2(NUM_PATTERNS + 1);
    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] misr_din;
    logic start_now, last, run;
    assign start_now = (state == IDLE || state == DONE) && start_bist;
    assign run       = state == RUN;
    assign last      = count == CW'(NUM_PATTERNS - 1);
`ifdef BIST_FAULT_INJECT_EN
    assign misr_din = cut_resp ^ WIDTH'(fault_inject);
`else
    assign misr_din = cut_resp;
`endif
    assign tpg_b = (tpg_a << (WIDTH / 2)) | (tpg_a >> (WIDTH - WIDTH / 2));
    lfsr_misr #(.WIDTH(WIDTH), .POLY_TAPS(POLY_TAPS), .SEED(LFSR_SEED)) u_lfsr (
        .clk(clk), .rst(rst), .en(run), .load(start_now), .din('0), .q(tpg_a)
    );
    lfsr_misr #(.WIDTH(WIDTH), .POLY_TAPS(POLY_TAPS), .SEED('0)) u_misr (
        .clk(clk), .rst(rst), .en(run), .load(start_now), .din(misr_din), .q(signature)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            bist_pass <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= run ? count + 1'b1 : start_now ? '0 : count;
            bist_pass <= (state == COMPARE) ? (signature == GOLDEN_SIG) : start_now ? 1'b0 : bist_pass;
        end
    end
    always_comb begin
        state_nxt   = state;
        bist_active = state == RUN || state == COMPARE;
        bist_done   = state == DONE;
        if (start_now) state_nxt = RUN;
        else if (run && last) state_nxt = COMPARE;
        else if (state == COMPARE) state_nxt = DONE;
    end
    // A zero seed would lock the LFSR at zero forever
    assert property (@(posedge clk) LFSR_SEED != '0);
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: directed self-checking bench; two instances differ only in GOLDEN_SIG
module tb_bist_engine;
    function automatic logic [7:0] model_sig();
        logic [7:0] a, m, r;
        a = 8'h01;
        m = 8'h00;
        for (int i = 0; i < 16; i++) begin
            r = a ^ {a[3:0], a[7:4]};
            m = {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00) ^ r;
            a = {1'b0, a[7:1]} ^ (a[0] ? 8'hB8 : 8'h00);
        end
        return m;
    endfunction
    localparam logic [7:0] SIG = model_sig();

    logic clk = 1'b0, rst = 1'b0, start_bist = 1'b0;
    logic g_active, g_pass, g_done, z_active, z_pass, z_done;
    logic [7:0] g_tpg_a, g_tpg_b, g_sig, z_tpg_a, z_tpg_b, z_sig;
    logic [7:0] g_resp, z_resp;
    logic [7:0] tpg_log [0:7];
    int vectors = 0, miscompares = 0;
`ifdef BIST_FAULT_INJECT_EN
    logic fault_inject = 1'b0;
`endif
    assign g_resp = g_tpg_a ^ g_tpg_b;
    assign z_resp = z_tpg_a ^ z_tpg_b;
    always #5 clk = ~clk;

    bist_engine #(.GOLDEN_SIG(SIG)) dut_g (
        .clk(clk), .rst(rst), .start_bist(start_bist), .bist_active(g_active), .bist_pass(g_pass),
        .bist_done(g_done), .tpg_a(g_tpg_a), .tpg_b(g_tpg_b), .cut_resp(g_resp), .signature(g_sig)
`ifdef BIST_FAULT_INJECT_EN
        , .fault_inject(fault_inject)
`endif
    );
    bist_engine #(.GOLDEN_SIG(8'h00)) dut_z (
        .clk(clk), .rst(rst), .start_bist(start_bist), .bist_active(z_active), .bist_pass(z_pass),
        .bist_done(z_done), .tpg_a(z_tpg_a), .tpg_b(z_tpg_b), .cut_resp(z_resp), .signature(z_sig)
`ifdef BIST_FAULT_INJECT_EN
        , .fault_inject(fault_inject)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_bist = 1'b1;
        tick();
        start_bist = 1'b0;
    endtask

    task automatic measure(input int from_cyc, output int act, output int done_at);
        int cyc;
        act = 0;
        done_at = 0;
        cyc = from_cyc;
        while (cyc < 40 && done_at == 0) begin
            if (cyc < 8) tpg_log[cyc] = g_tpg_a;
            if (g_active) act++;
            if (g_done) done_at = cyc;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++; if (g_active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b expected 0", g_active); end
        vectors++; if (g_pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass got %b expected 0", g_pass); end
        vectors++; if (g_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", g_done); end
        vectors++; if (g_tpg_a !== 8'h01) begin miscompares++; $display("FAIL reset_tpg_a got %h expected 01", g_tpg_a); end
        vectors++; if (g_sig !== 8'h00) begin miscompares++; $display("FAIL reset_sig got %h expected 00", g_sig); end
    endtask

    task automatic test_run();
        int act, done_at;
        pulse_start();
        measure(1, act, done_at);
        vectors++; if (tpg_log[1] !== 8'h01) begin miscompares++; $display("FAIL tpg_c1 got %h expected 01", tpg_log[1]); end
        vectors++; if (tpg_log[2] !== 8'hB8) begin miscompares++; $display("FAIL tpg_c2 got %h expected b8", tpg_log[2]); end
        vectors++; if (tpg_log[3] !== 8'h5C) begin miscompares++; $display("FAIL tpg_c3 got %h expected 5c", tpg_log[3]); end
        vectors++; if (tpg_log[4] !== 8'h2E) begin miscompares++; $display("FAIL tpg_c4 got %h expected 2e", tpg_log[4]); end
        vectors++; if (act !== 17) begin miscompares++; $display("FAIL active_cycles got %0d expected 17", act); end
        vectors++; if (done_at !== 18) begin miscompares++; $display("FAIL done_cycle got %0d expected 18", done_at); end
        vectors++; if (g_sig !== SIG) begin miscompares++; $display("FAIL run_sig got %h expected %h", g_sig, SIG); end
        vectors++; if (g_pass !== 1'b1) begin miscompares++; $display("FAIL golden_pass got %b expected 1", g_pass); end
        vectors++; if (z_pass !== (SIG == 8'h00)) begin miscompares++; $display("FAIL zero_golden_pass got %b expected %b", z_pass, SIG == 8'h00); end
        repeat (5) tick();
        vectors++; if (g_done !== 1'b1 || g_active !== 1'b0) begin miscompares++; $display("FAIL done_hold got done=%b active=%b expected done=1 active=0", g_done, g_active); end
        vectors++; if (g_pass !== 1'b1 || g_sig !== SIG) begin miscompares++; $display("FAIL result_hold got pass=%b sig=%h expected pass=1 sig=%h", g_pass, g_sig, SIG); end
    endtask

    task automatic test_back_to_back();
        int act, done_at;
        pulse_start();
        vectors++; if (g_done !== 1'b0 || g_active !== 1'b1) begin miscompares++; $display("FAIL restart_flags got done=%b active=%b expected done=0 active=1", g_done, g_active); end
        vectors++; if (g_tpg_a !== 8'h01) begin miscompares++; $display("FAIL restart_tpg got %h expected 01", g_tpg_a); end
        repeat (4) tick();
        pulse_start();
        measure(6, act, done_at);
        vectors++; if (act !== 12) begin miscompares++; $display("FAIL ignored_start_active got %0d expected 12", act); end
        vectors++; if (done_at !== 18) begin miscompares++; $display("FAIL ignored_start_done got %0d expected 18", done_at); end
        vectors++; if (g_sig !== SIG) begin miscompares++; $display("FAIL ignored_start_sig got %h expected %h", g_sig, SIG); end
    endtask

    task automatic test_reset_mid_run();
        int act, done_at;
        pulse_start();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (g_active !== 1'b0 || g_done !== 1'b0 || g_pass !== 1'b0) begin miscompares++; $display("FAIL midrst_flags got active=%b done=%b pass=%b expected 0 0 0", g_active, g_done, g_pass); end
        vectors++; if (g_tpg_a !== 8'h01 || g_sig !== 8'h00) begin miscompares++; $display("FAIL midrst_regs got tpg=%h sig=%h expected 01 00", g_tpg_a, g_sig); end
        rst = 1'b1;
        start_bist = 1'b1;
        tick();
        rst = 1'b0;
        start_bist = 1'b0;
        tick();
        vectors++; if (g_active !== 1'b0) begin miscompares++; $display("FAIL rst_wins_active got %b expected 0", g_active); end
        pulse_start();
        measure(1, act, done_at);
        vectors++; if (act !== 17 || done_at !== 18) begin miscompares++; $display("FAIL rerun_timing got active=%0d done=%0d expected 17 18", act, done_at); end
        vectors++; if (g_sig !== SIG || g_pass !== 1'b1) begin miscompares++; $display("FAIL rerun_result got sig=%h pass=%b expected %h 1", g_sig, g_pass, SIG); end
    endtask

`ifdef BIST_FAULT_INJECT_EN
    task automatic test_fault_inject();
        int act, done_at;
        pulse_start();
        repeat (3) tick();
        fault_inject = 1'b1;
        tick();
        fault_inject = 1'b0;
        measure(5, act, done_at);
        vectors++; if (done_at !== 18) begin miscompares++; $display("FAIL fault_done got %0d expected 18", done_at); end
        vectors++; if (g_sig === SIG) begin miscompares++; $display("FAIL fault_sig got %h expected not %h", g_sig, SIG); end
        vectors++; if (g_pass !== 1'b0) begin miscompares++; $display("FAIL fault_pass got %b expected 0", g_pass); end
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef BIST_FAULT_INJECT_EN
        test_fault_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
